// File: rtl/fir_frame_feeder_pkg.sv
// -----------------------------------------------------------------------------
// fir_frame_feeder_pkg
// Shared definitions for the FIR frame feeder and its skid buffer.
//   FRAME_LEN_DEFAULT : samples per frame (FIR tap count == core FIFO depth)
//   DATA_W_DEFAULT    : sample width
//   CNT_W             : width of the frame / drop counters
//   feeder_state_t    : feeder FSM states (also exported on dbg_state)
// -----------------------------------------------------------------------------
package fir_frame_feeder_pkg;

    localparam int FRAME_LEN_DEFAULT = 64;
    localparam int DATA_W_DEFAULT    = 16;
    localparam int CNT_W             = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/fir_skid_buf2.sv
// -----------------------------------------------------------------------------
// fir_skid_buf2
// Two-entry first-in first-out holding buffer in front of the feeder FSM.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_push, i_push_data : write one word (caller guarantees room, counting a
//                         same-cycle pop as freeing a slot)
//   i_pop               : drop the head word (caller guarantees count != 0)
//   o_head              : oldest stored word, valid while o_count != 0
//   o_count             : number of stored words, 0..2
// Entry 0 is always the head; a pop shifts entry 1 down so the read side
// never needs a pointer.
// -----------------------------------------------------------------------------
module fir_skid_buf2
    import fir_frame_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem0;
    logic [DATA_W-1:0] r_mem1;
    logic [1:0]        r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_push_data;
                    else                 r_mem1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever
                    // remains after the head leaves.
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem0;
    assign o_count = r_count;

endmodule

// File: rtl/fir_frame_feeder.sv
// -----------------------------------------------------------------------------
// fir_frame_feeder
// Upstream stage of the 64-tap FIR core. Buffers a valid/ready sample stream
// in a 2-entry skid buffer and writes whole FRAME_LEN-word frames into the
// core's input FIFO, then waits for the core to start draining before the
// next frame may begin.
//
// Handshake: a sample transfers on a rising clk edge where s_valid && s_ready;
// s_ready is registered and never depends combinationally on s_valid.
//
// Ports:
//   clk, reset        : clock (shared with FIR core), async active-low reset
//   s_data/s_valid    : input sample stream
//   s_ready           : feeder can accept (registered)
//   able2write        : core's able2write_out
//   X, in_write_ctrlX : FIFO data / write strobe (registered)
//   frame_done        : pulse with the last word of each frame (registered)
//   frame_cnt         : completed frames, wraps modulo 2^16
//   drop_cnt          : discarded samples (drop mode only, else 0)
//   dbg_state         : current FSM state, for observation only
//
// Build option FRAME_FEEDER_DROP_EN: s_ready is tied high and samples that
// find the buffer full are discarded and counted in drop_cnt.
// -----------------------------------------------------------------------------
module fir_frame_feeder
    import fir_frame_feeder_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              able2write,
    output logic [DATA_W-1:0] X,
    output logic              in_write_ctrlX,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output feeder_state_t     dbg_state
);

    localparam int                  WR_IDX_W = $clog2(FRAME_LEN) + 1;
    localparam logic [WR_IDX_W-1:0] LAST_IDX = WR_IDX_W'(FRAME_LEN - 1);

    feeder_state_t       r_state;
    logic [WR_IDX_W-1:0] r_wr_idx;
    logic [DATA_W-1:0]   r_x;
    logic                r_wr;
    logic                r_done;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_head;
    logic [1:0]          w_count;

    // One word leaves the buffer on every FILL cycle that has data.
    assign w_pop = (r_state == FILL) && (w_count != 2'd0);

`ifdef FRAME_FEEDER_DROP_EN
    logic             w_room;
    logic [CNT_W-1:0] r_drop_cnt;

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign w_room   = (w_count != 2'd2) || w_pop;
    assign w_push   = s_valid && w_room;
    assign s_ready  = 1'b1;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (s_valid && !w_room) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end
`else
    logic       r_s_ready;
    logic [1:0] w_count_nxt;

    assign w_push      = s_valid && r_s_ready;
    assign w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};
    assign s_ready     = r_s_ready;
    assign drop_cnt    = '0;

    // Ready reflects the occupancy after this edge, so a full buffer is
    // never offered to the source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= (w_count_nxt != 2'd2);
        end
    end
`endif

    fir_skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (s_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wr_idx    <= '0;
            r_x         <= '0;
            r_wr        <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (able2write) begin
                        r_state  <= FILL;
                        r_wr_idx <= '0;
                    end
                end
                FILL: begin
                    if (w_pop) begin
                        r_x  <= w_head;
                        r_wr <= 1'b1;
                        if (r_wr_idx == LAST_IDX) begin
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            r_wr_idx    <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_wr_idx <= r_wr_idx + WR_IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Only a low able2write (core reading a full FIFO) ends
                    // the drain; a lingering high from before the fill is
                    // deliberately ignored here.
                    if (!able2write) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign X              = r_x;
    assign in_write_ctrlX = r_wr;
    assign frame_done     = r_done;
    assign frame_cnt      = r_frame_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fir_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_fir_frame_feeder
// Directed sequence with random sample values. Reference model: every sample
// that transfers is queued in exp_q; every FIFO write must carry the oldest
// queued sample, and every FRAME_LEN-th write must be a frame boundary.
// -----------------------------------------------------------------------------
module tb_fir_frame_feeder;
    import fir_frame_feeder_pkg::*;

    localparam int DW = 16;
    localparam int FL = 64;
`ifdef FRAME_FEEDER_DROP_EN
    localparam logic DROP_MODE = 1'b1;
`else
    localparam logic DROP_MODE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          able2write;
    logic [DW-1:0] X;
    logic          in_write_ctrlX;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;
    feeder_state_t dbg_state;

    always #5 clk = ~clk;

    fir_frame_feeder #(
        .FRAME_LEN (FL),
        .DATA_W    (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .able2write     (able2write),
        .X              (X),
        .in_write_ctrlX (in_write_ctrlX),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_tests    = 0;
    int            n_fail     = 0;
    logic [DW-1:0] exp_q[$];
    int            m_word     = 0;   // words written in the current frame
    int            m_frames   = 0;   // frames completed since reset
    int            m_drops    = 0;
    int            strobe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted samples enter the model queue.
    always @(posedge clk) begin
        if (reset) begin
`ifdef FRAME_FEEDER_DROP_EN
            if (s_valid) begin
                if (exp_q.size() < 2) exp_q.push_back(s_data);
                else                  m_drops++;
            end
`else
            if (s_valid && s_ready) exp_q.push_back(s_data);
`endif
        end
    end

    // FIFO writes are checked against the model queue.
    always @(negedge clk) begin : monitor
        logic          exp_done;
        logic [DW-1:0] d;
        if (reset) begin
            exp_done = 1'b0;
            if (in_write_ctrlX) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    check("write_without_sample", 32'(in_write_ctrlX), 32'd0);
                end else begin
                    d = exp_q.pop_front();
                    check("x_data", 32'(X), 32'(d));
                end
                exp_done = (m_word == FL - 1);
                if (exp_done) begin
                    m_word   = 0;
                    m_frames = (m_frames + 1) % 65536;
                    check("frame_cnt_at_done", 32'(frame_cnt), 32'(m_frames));
                end else begin
                    m_word++;
                end
            end
            check("frame_done", 32'(frame_done), 32'(exp_done));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one sample; returns at the negedge after it transferred.
    task automatic send(input logic [DW-1:0] d);
        int guard = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int g = 0;
        while (m_frames != target && g < budget) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("frame_wait", 32'(m_frames), 32'(target));
    endtask

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        able2write = 1'b0;
        #1 reset   = 1'b0;
        cycles(3);

        // Reset values
        check("rst_s_ready",   32'(s_ready),        32'(DROP_MODE));
        check("rst_x",         32'(X),              32'd0);
        check("rst_wr",        32'(in_write_ctrlX), 32'd0);
        check("rst_done",      32'(frame_done),     32'd0);
        check("rst_frame_cnt", 32'(frame_cnt),      32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),       32'd0);
        check("rst_state",     32'(dbg_state),      32'(IDLE));

        able2write = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        check("s_ready_after_release", 32'(s_ready), 32'd1);

        // Frame 1: continuous 0..63
        strobe_cnt = 0;
        for (int i = 0; i < FL; i++) send(DW'(i));
        wait_frames(1, 200);
        check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f1_state",     32'(dbg_state), 32'(DRAIN));
        check("f1_strobes",   32'(strobe_cnt), 32'(FL));

        // Samples during DRAIN stay buffered; stale able2write high ignored
        send(DW'($urandom_range(0, 65535)));
        send(DW'($urandom_range(0, 65535)));
        check("s_ready_full", 32'(s_ready), 32'(DROP_MODE));
        strobe_cnt = 0;
        cycles(10);
        check("stale_high_no_write", 32'(strobe_cnt), 32'd0);
        check("stale_high_state",    32'(dbg_state),  32'(DRAIN));
        able2write = 1'b0;
        cycles(3);
        check("drain_to_idle",       32'(dbg_state),  32'(IDLE));
        check("idle_no_write",       32'(strobe_cnt), 32'd0);
        able2write = 1'b1;
        cycles(4);
        check("buffered_first_words", 32'(strobe_cnt), 32'd2);

        // Frame 2 remainder with s_valid toggling every cycle
        for (int i = 0; i < FL - 2; i++) begin
            send(DW'($urandom_range(0, 65535)));
            cycles(1);
        end
        wait_frames(2, 200);
        check("f2_frame_cnt", 32'(frame_cnt),  32'd2);
        check("f2_strobes",   32'(strobe_cnt), 32'(FL));

        // Frame 3: latency from an empty buffer in FILL, then continuous
        able2write = 1'b0;
        cycles(2);
        able2write = 1'b1;
        cycles(2);
        check("f3_state_fill", 32'(dbg_state), 32'(FILL));
        send(DW'($urandom_range(0, 65535)));
        check("latency_not_early", 32'(in_write_ctrlX), 32'd0);
        @(negedge clk);
        check("latency_strobe",    32'(in_write_ctrlX), 32'd1);
        for (int i = 1; i < FL; i++) send(DW'($urandom_range(0, 65535)));
        wait_frames(3, 3);
        check("f3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Frame 4: reset after word 20, then a fresh frame
        able2write = 1'b0;
        cycles(2);
        able2write = 1'b1;
        cycles(2);
        for (int i = 0; i < 21; i++) send(DW'($urandom_range(1, 65535)));
        begin
            int g = 0;
            while (m_word != 21 && g < 20) begin
                @(negedge clk);
                g++;
            end
            check("mid_frame_reach_word20", 32'(m_word), 32'd21);
        end
        #2 reset = 1'b0;
        exp_q.delete();
        m_word   = 0;
        m_frames = 0;
        #1;
        check("async_rst_x",         32'(X),              32'd0);
        check("async_rst_wr",        32'(in_write_ctrlX), 32'd0);
        check("async_rst_s_ready",   32'(s_ready),        32'(DROP_MODE));
        check("async_rst_frame_cnt", 32'(frame_cnt),      32'd0);
        check("async_rst_state",     32'(dbg_state),      32'(IDLE));
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FL; i++) send(DW'($urandom_range(0, 65535)));
        wait_frames(1, 200);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef FRAME_FEEDER_DROP_EN
        // Five samples into the DRAIN-state buffer: two kept, three dropped
        for (int i = 0; i < 5; i++) begin
            send(DW'($urandom_range(0, 65535)));
            check("drop_s_ready", 32'(s_ready), 32'd1);
        end
        cycles(1);
        check("drop_cnt", 32'(drop_cnt), 32'd3);
        check("drop_model", 32'(drop_cnt), 32'(m_drops));
        able2write = 1'b0;
        cycles(2);
        able2write = 1'b1;
        cycles(4);
        for (int i = 0; i < FL - 2; i++) send(DW'($urandom_range(0, 65535)));
        wait_frames(2, 200);
        check("drop_frame_cnt", 32'(frame_cnt), 32'd2);
`else
        check("drop_cnt_tied_zero", 32'(drop_cnt), 32'd0);
`endif

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_frame_feeder.md
# fir_frame_feeder

Upstream stage of the 64-tap FIR core. Accepts a valid/ready sample stream, buffers it in a 2-entry skid buffer, and writes exactly 64-sample frames into the core's input FIFO via `X`/`in_write_ctrlX`. Writes occur only while the core advertises `able2write_out`. Tracks the core's fill/drain cycle so a new frame never starts until the FIFO has emptied.

## Interface
- `FRAME_LEN`, 64: samples per frame; must equal the FIR tap count and FIFO depth.
- `DATA_W`, 16: sample width.
- `clk`  in  1  single clock, shared with the FIR core.
- `reset`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  input sample, two's complement.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  feeder can accept; transfer on `s_valid && s_ready` at posedge.
- `able2write`  in  1  core's `able2write_out`.
- `X`  out  DATA_W  sample to core FIFO.
- `in_write_ctrlX`  out  1  FIFO write strobe, one word per high cycle.
- `frame_done`  out  1  one-cycle pulse on the cycle the last word of a frame is written.
- `frame_cnt`  out  16  completed frames, wraps at 0xFFFF→0.
- `drop_cnt`  out  16  samples dropped; present only with `FRAME_FEEDER_DROP_EN`, otherwise tied 0.

## Operation
- States:
  - IDLE: wait for `able2write`=1 → FILL, with `wr_idx`=0.
  - FILL: write one word on each cycle the skid buffer is non-empty. `wr_idx` increments per write. The write with `wr_idx`=FRAME_LEN-1 pulses `frame_done`, increments `frame_cnt`, and goes to DRAIN.
  - DRAIN: wait for `able2write`=0, i.e. the core saw full and is reading → IDLE. DRAIN never transitions directly on `able2write`=1, so a stale high is ignored.
- Skid buffer:
  - 2 entries, first-in first-out.
  - `s_ready` = buffer count < 2, registered.
  - Accept and pop in the same cycle are legal; count is unchanged.
  - Samples accepted outside FILL stay buffered and are never lost.
- Write rules:
  - No write outside FILL.
  - No partial frames.
  - Stalled input mid-frame keeps `in_write_ctrlX`=0 and holds state and `wr_idx`.
- Counters: `frame_cnt` and `drop_cnt` wrap modulo 2^16 with no saturation.
- Reset, including mid-frame: state→IDLE, buffer emptied, `wr_idx`=0, counters=0. The partial frame is abandoned. The core is reset by the same net.
- Reset values: `s_ready`=0 while asserted, 1 on the first cycle after release. `X`=0, `in_write_ctrlX`=0, `frame_done`=0, `frame_cnt`=0, `drop_cnt`=0.

## Timing
- `X`, `in_write_ctrlX`, `frame_done` are registered.
- Latency, sample accepted at edge N with buffer empty and state FILL: appears on `X` with `in_write_ctrlX`=1 in the cycle after edge N+1, i.e. 2-edge latency.
- Throughput: one word per cycle in FILL, so a full frame takes 64 consecutive strobe cycles given continuous input.
- IDLE→FILL: one cycle after `able2write` is sampled high.
- DRAIN→IDLE: one cycle after `able2write` is sampled low.

## Configuration
- `FRAME_FEEDER_DROP_EN` defined:
  - `s_ready` is tied to 1.
  - A sample arriving while the buffer is full is discarded and `drop_cnt` increments.
  - Feeder never backpressures; used with free-running ADC sources.
- Undefined: backpressure operation as above. `drop_cnt` output exists and reads 0, with no counter logic.

## Structure
- Package `fir_frame_feeder_pkg`:
  - `FRAME_LEN` and `DATA_W` defaults.
  - State enum `feeder_state_t` {IDLE, FILL, DRAIN}.
  - `CNT_W`=16.
- Sub-module `fir_skid_buf2`: 2-entry synchronous buffer with push/pop/count, no full/empty flags exported beyond count.
- Top holds the FSM, `wr_idx` (log2 FRAME_LEN + 1 bits), and counters.

## Test plan
- Reset release, `able2write`=1, continuous `s_data`=0..63 → 64 strobes carrying 0..63 in order; `frame_done` on word 63; `frame_cnt`=1; state DRAIN.
- After a frame, hold `able2write`=1 for 10 cycles, then 0, then 1 → no writes until the 0→1 sequence completes; second frame starts 1 cycle after `able2write`=1.
- `s_valid` toggling 1/0 every cycle → strobe on alternate cycles; 64 words over ~128 cycles; no duplicates or gaps.
- Input arrives during DRAIN → `s_ready` drops after 2 accepts; those 2 samples are the first 2 words of the next frame.
- Assert `reset` after word 20 → outputs 0 immediately (asynchronous); after release, the next frame starts at the new first sample; `frame_cnt`=0.
- With `FRAME_FEEDER_DROP_EN`, 5 samples during DRAIN → 2 kept, `drop_cnt`=3, `s_ready` constantly 1.
